time_setter: RTL and testbench
==============================

# time_setter

Button-driven time-entry controller upstream of the alarm clock core. It debounces three raw push-buttons and lets the user edit a four-digit HH:MM buffer one digit at a time, rejecting invalid times. When editing finishes, it presents the buffer on the core's time inputs together with a one-cycle `ldTime` or `ldAlarm` strobe. It also exports the edit state so a display stage can blink the selected digit.

## Interface

Parameters:
- `DB_CYCLES`, default 20000: consecutive stable cycles required before a synchronized button level is accepted. Minimum 1.

Ports:
- `clk`  input  1  system clock, all logic on the rising edge
- `reset`  input  1  asynchronous, active-high reset
- `btnSet`  input  1  raw button, asynchronous: start editing the current time; advance to the next digit
- `btnAlm`  input  1  raw button, asynchronous: start editing the alarm time
- `btnUp`  input  1  raw button, asynchronous: increment the selected digit
- `hourSet1`  output  2  edit buffer, hour tens digit
- `hourSet0`  output  4  edit buffer, hour units digit
- `minSet1`  output  4  edit buffer, minute tens digit
- `minSet0`  output  4  edit buffer, minute units digit
- `ldTime`  output  1  one-cycle strobe: commit the buffer as the current time
- `ldAlarm`  output  1  one-cycle strobe: commit the buffer as the alarm time
- `editing`  output  1  high while the block is in any EDIT state
- `digitSel`  output  2  selected digit: 0=H1, 1=H0, 2=M1, 3=M0. Forced to 0 outside EDIT states.

## Operation

Input conditioning, per button:
- 2-flop synchronizer.
- Debounce counter: the debounced level flips after the synchronized level has differed from it for `DB_CYCLES` consecutive cycles. Any agreeing cycle clears the counter.
- A rising edge of the debounced level produces an internal one-cycle press pulse (`pSet`, `pAlm`, `pUp`).

State machine states: IDLE, EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0, COMMIT.
- IDLE:
  - `pSet` sets target=TIME and moves to EDIT_H1.
  - else `pAlm` sets target=ALARM and moves to EDIT_H1.
  - `pUp` is ignored.
- EDIT_x:
  - `pUp` increments the selected digit.
  - `pSet` advances to the next digit; from EDIT_M0 it advances to COMMIT.
  - `pAlm` is ignored.
- COMMIT: strobes `ldTime` (target=TIME) or `ldAlarm` (target=ALARM) for exactly one cycle, then moves to IDLE unconditionally.
- The buffer keeps its value between sessions: editing starts from the last committed or edited value, not 00:00.

Digit rules (increments wrap to 0):
- H1: 0..2.
- H0: 0..9 when H1<2; 0..3 when H1=2.
- M1: 0..5.
- M0: 0..9.
- When H1 increments 1→2 while H0>3, H0 is clamped to 3 on the same edge.
- The buffer never holds an invalid time (above 23:59, or any digit out of range).

Simultaneous events:
- `pSet` and `pAlm` in IDLE: TIME wins.
- `pUp` and `pSet` in EDIT: the increment applies to the current digit, then the state advances, on the same edge.

Reset (at any time, including mid-edit or during COMMIT): immediately IDLE, buffer 00:00, target=TIME, debouncers cleared to level 0 with counters 0. No strobe is emitted.

## Timing

- Reset values: `hourSet1`=0, `hourSet0`=0, `minSet1`=0, `minSet0`=0, `ldTime`=0, `ldAlarm`=0, `editing`=0, `digitSel`=0.
- All outputs are registered.
- Latency from a raw button edge to its press pulse: 2 synchronizer cycles + `DB_CYCLES` cycles. The FSM and buffer respond on the edge after the pulse.
- A held button produces exactly one pulse. A glitch shorter than `DB_CYCLES` cycles produces none.
- The `ldTime`/`ldAlarm` strobe is high in the single cycle spent in COMMIT. The `*Set` outputs are stable from the last EDIT cycle through the strobe cycle.
- `ldTime` and `ldAlarm` are never high together.

## Structure

- Shared package holds:
  - the state enum `ts_state_t` (IDLE, EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0, COMMIT);
  - the target enum (TIME, ALARM);
  - the digit-limit constants H1_MAX=2, H0_MAX=9, H0_MAX_H1EQ2=3, M1_MAX=5, M0_MAX=9.
- One sub-module `btn_debounce`, instantiated three times. It contains the synchronizer, the counter (width `$clog2(DB_CYCLES+1)`) and the rising-edge pulse.
- FSM and digit arithmetic live in `time_setter`.

## Test plan

All scenarios use `DB_CYCLES`=4.
- Reset mid-edit: enter EDIT_M1, assert `reset` for 1 cycle → IDLE, buffer 00:00, no strobe, `editing`=0, `digitSel`=0.
- Full time entry: press Set, then Up×2, Set, Up×3, Set, Up×4, Set, Up×5, Set → `ldTime` high exactly one cycle with the outputs showing 2:3:4:5 (23:45); `ldAlarm` stays 0.
- Alarm entry and wrap: press Alm, then Up×3 on H1 → H1=0 (wraps 0→1→2→0). Press Up×10 on M0 → wraps to 0. Finish the entry → `ldAlarm` strobe only.
- H0 clamp: buffer at 19:00, in EDIT_H1, press Up → buffer 23:00; then in EDIT_H0, press Up → 20:00.
- Debounce: a 3-cycle raw pulse on `btnUp` → no increment. A 40-cycle hold → exactly one increment, arriving 6 cycles (2 sync + 4 debounce) after the raw edge.
- Simultaneous buttons: Set and Alm pressed together in IDLE → target TIME. Up and Set pressed together in EDIT_H0 with H0=4 → H0=5 and state EDIT_M1.

Source files
------------

// File: rtl/time_setter_pkg.sv
// Shared types and digit limits for the time-entry controller.
package time_setter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_H1,
    EDIT_H0,
    EDIT_M1,
    EDIT_M0,
    COMMIT
  } ts_state_t;

  typedef enum logic {
    TIME,
    ALARM
  } ts_target_t;

  localparam logic [3:0] H1_MAX       = 4'd2;
  localparam logic [3:0] H0_MAX       = 4'd9;
  localparam logic [3:0] H0_MAX_H1EQ2 = 4'd3;
  localparam logic [3:0] M1_MAX       = 4'd5;
  localparam logic [3:0] M0_MAX       = 4'd9;

  // Increment a BCD digit, wrapping to zero once it reaches its limit.
  function automatic logic [3:0] inc_wrap(input logic [3:0] v, input logic [3:0] max);
    return (v >= max) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/time_setter_btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, stability counter, press pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw_i;
      s2_q <= s1_q;
    end
  end

  // Flip the accepted level only after DB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounced level, counter and edge-detect history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
    end
  end

  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/time_setter.sv
// Button-driven HH:MM entry controller feeding the alarm clock core.
module time_setter
  import time_setter_pkg::*;
#(
  parameter int DB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnSet,
  input  logic       btnAlm,
  input  logic       btnUp,
  output logic [1:0] hourSet1,
  output logic [3:0] hourSet0,
  output logic [3:0] minSet1,
  output logic [3:0] minSet0,
  output logic       ldTime,
  output logic       ldAlarm,
  output logic       editing,
  output logic [1:0] digitSel
);

  logic p_set, p_alm, p_up;

  ts_state_t  state_q, state_d;
  ts_target_t target_q, target_d;
  logic [1:0] h1_q, h1_d;
  logic [3:0] h0_q, h0_d;
  logic [3:0] m1_q, m1_d;
  logic [3:0] m0_q, m0_d;
  logic       ld_time_q, ld_time_d;
  logic       ld_alarm_q, ld_alarm_d;
  logic       editing_q, editing_d;
  logic [1:0] digit_sel_q, digit_sel_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk(clk), .reset(reset), .btn_raw_i(btnSet), .press_o(p_set)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_alm (
    .clk(clk), .reset(reset), .btn_raw_i(btnAlm), .press_o(p_alm)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .btn_raw_i(btnUp), .press_o(p_up)
  );

  // Next state, digit arithmetic and registered-output decode.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    m1_d     = m1_q;
    m0_d     = m0_q;

    case (state_q)
      IDLE: begin
        if (p_set) begin
          target_d = TIME;
          state_d  = EDIT_H1;
        end else if (p_alm) begin
          target_d = ALARM;
          state_d  = EDIT_H1;
        end
      end
      EDIT_H1: begin
        if (p_up) begin
          h1_d = ({2'b00, h1_q} >= H1_MAX) ? 2'd0 : h1_q + 2'd1;
          // Entering the 20s hour band must not leave H0 above 3.
          if (({2'b00, h1_q} + 4'd1 == H1_MAX) && (h0_q > H0_MAX_H1EQ2)) begin
            h0_d = H0_MAX_H1EQ2;
          end
        end
        if (p_set) state_d = EDIT_H0;
      end
      EDIT_H0: begin
        if (p_up) h0_d = inc_wrap(h0_q, ({2'b00, h1_q} == H1_MAX) ? H0_MAX_H1EQ2 : H0_MAX);
        if (p_set) state_d = EDIT_M1;
      end
      EDIT_M1: begin
        if (p_up) m1_d = inc_wrap(m1_q, M1_MAX);
        if (p_set) state_d = EDIT_M0;
      end
      EDIT_M0: begin
        if (p_up) m0_d = inc_wrap(m0_q, M0_MAX);
        if (p_set) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    ld_time_d   = (state_d == COMMIT) && (target_d == TIME);
    ld_alarm_d  = (state_d == COMMIT) && (target_d == ALARM);
    editing_d   = 1'b0;
    digit_sel_d = 2'd0;
    case (state_d)
      EDIT_H1: begin editing_d = 1'b1; digit_sel_d = 2'd0; end
      EDIT_H0: begin editing_d = 1'b1; digit_sel_d = 2'd1; end
      EDIT_M1: begin editing_d = 1'b1; digit_sel_d = 2'd2; end
      EDIT_M0: begin editing_d = 1'b1; digit_sel_d = 2'd3; end
      default: begin editing_d = 1'b0; digit_sel_d = 2'd0; end
    endcase
  end

  // State, edit buffer and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= TIME;
      h1_q        <= '0;
      h0_q        <= '0;
      m1_q        <= '0;
      m0_q        <= '0;
      ld_time_q   <= 1'b0;
      ld_alarm_q  <= 1'b0;
      editing_q   <= 1'b0;
      digit_sel_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      ld_time_q   <= ld_time_d;
      ld_alarm_q  <= ld_alarm_d;
      editing_q   <= editing_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign hourSet1 = h1_q;
  assign hourSet0 = h0_q;
  assign minSet1  = m1_q;
  assign minSet0  = m0_q;
  assign ldTime   = ld_time_q;
  assign ldAlarm  = ld_alarm_q;
  assign editing  = editing_q;
  assign digitSel = digit_sel_q;

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: directed scenarios plus random button traffic.
module tb_time_setter;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btnSet = 1'b0, btnAlm = 1'b0, btnUp = 1'b0;
  logic [1:0] hourSet1;
  logic [3:0] hourSet0, minSet1, minSet0;
  logic       ldTime, ldAlarm, editing;
  logic [1:0] digitSel;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit alarm;
    int h1, h0, m1, m0;
  } exp_t;
  exp_t sb[$];

  // Reference model: time held as four decimal digits plus session state.
  int md[4];
  bit m_edit;
  int m_idx;
  bit m_alarm;

  time_setter #(.DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset),
    .btnSet(btnSet), .btnAlm(btnAlm), .btnUp(btnUp),
    .hourSet1(hourSet1), .hourSet0(hourSet0),
    .minSet1(minSet1), .minSet0(minSet0),
    .ldTime(ldTime), .ldAlarm(ldAlarm),
    .editing(editing), .digitSel(digitSel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) md[i] = 0;
    m_edit  = 0;
    m_idx   = 0;
    m_alarm = 0;
  endtask

  // Increment the selected digit so that HH:MM stays a legal 24h time.
  task automatic model_inc();
    case (m_idx)
      0: begin
        md[0] = (md[0] + 1) % 3;
        if (md[0] * 10 + md[1] > 23) md[1] = 3;
      end
      1: md[1] = (md[1] + 1) % ((md[0] == 2) ? 4 : 10);
      2: md[2] = (md[2] + 1) % 6;
      default: md[3] = (md[3] + 1) % 10;
    endcase
  endtask

  task automatic model_apply(input bit s, input bit a, input bit u);
    exp_t e;
    if (!m_edit) begin
      if (s) begin
        m_alarm = 0; m_edit = 1; m_idx = 0;
      end else if (a) begin
        m_alarm = 1; m_edit = 1; m_idx = 0;
      end
    end else begin
      if (u) model_inc();
      if (s) begin
        if (m_idx == 3) begin
          e.alarm = m_alarm;
          e.h1 = md[0]; e.h0 = md[1]; e.m1 = md[2]; e.m0 = md[3];
          sb.push_back(e);
          m_edit = 0;
          m_idx  = 0;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic check_state();
    chk("h1", hourSet1, md[0]);
    chk("h0", hourSet0, md[1]);
    chk("m1", minSet1, md[2]);
    chk("m0", minSet0, md[3]);
    chk("editing", editing, m_edit);
    chk("digitSel", digitSel, m_edit ? m_idx : 0);
  endtask

  // One clean press of any button combination, held then released past the debounce window.
  task automatic press(input bit s, input bit a, input bit u);
    @(posedge clk); #1;
    model_apply(s, a, u);
    btnSet = s; btnAlm = a; btnUp = u;
    repeat (DB + 4) @(posedge clk);
    #1;
    btnSet = 0; btnAlm = 0; btnUp = 0;
    repeat (DB + 6) @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  // Monitor: every strobe must match the oldest expected commit.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_strobe <= 1'b0;
    end else begin
      if (ldTime || ldAlarm) begin
        exp_t e;
        chk("strobe_exclusive", int'(ldTime && ldAlarm), 0);
        chk("strobe_width", prev_strobe, 0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL strobe_unexpected: got ldTime=%0d ldAlarm=%0d, expected no strobe (t=%0t)",
                   ldTime, ldAlarm, $time);
        end else begin
          e = sb.pop_front();
          chk("strobe_ldAlarm", ldAlarm, e.alarm);
          chk("strobe_ldTime", ldTime, !e.alarm);
          chk("strobe_h1", hourSet1, e.h1);
          chk("strobe_h0", hourSet0, e.h0);
          chk("strobe_m1", minSet1, e.m1);
          chk("strobe_m0", minSet0, e.m0);
          chk("strobe_editing", editing, 0);
        end
      end
      prev_strobe <= ldTime || ldAlarm;
    end
  end

  initial begin
    int r;
    int mask;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_h1", hourSet1, 0);
    chk("rst_h0", hourSet0, 0);
    chk("rst_m1", minSet1, 0);
    chk("rst_m0", minSet0, 0);
    chk("rst_ldTime", ldTime, 0);
    chk("rst_ldAlarm", ldAlarm, 0);
    chk("rst_editing", editing, 0);
    chk("rst_digitSel", digitSel, 0);
    @(posedge clk); #1 reset = 0;

    // Full time entry 23:45
    press(1, 0, 0);
    repeat (2) press(0, 0, 1);
    press(1, 0, 0);
    repeat (3) press(0, 0, 1);
    press(1, 0, 0);
    repeat (4) press(0, 0, 1);
    press(1, 0, 0);
    repeat (5) press(0, 0, 1);
    press(1, 0, 0);
    chk("entry_hh", hourSet1 * 10 + hourSet0, 23);
    chk("entry_mm", minSet1 * 10 + minSet0, 45);

    // Reset in the middle of an edit session
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    chk("pre_reset_digitSel", digitSel, 2);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    model_reset();
    @(negedge clk);
    chk("midrst_hhmm", hourSet1 * 1000 + hourSet0 * 100 + minSet1 * 10 + minSet0, 0);
    chk("midrst_editing", editing, 0);
    chk("midrst_digitSel", digitSel, 0);
    chk("midrst_strobe", int'(ldTime || ldAlarm), 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_state();

    // Alarm entry with wraparound of H1 and M0
    press(0, 1, 0);
    repeat (3) press(0, 0, 1);
    chk("alm_h1_wrap", hourSet1, 0);
    repeat (3) press(1, 0, 0);
    repeat (10) press(0, 0, 1);
    chk("alm_m0_wrap", minSet0, 0);
    press(1, 0, 0);

    // Clamp: reach 19:00, then H1 up gives 23:00, then H0 up gives 20:00
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    repeat (9) press(0, 0, 1);
    repeat (3) press(1, 0, 0);
    press(1, 0, 0);
    chk("clamp_start", hourSet1 * 10 + hourSet0, 19);
    press(0, 0, 1);
    chk("clamp_23", hourSet1 * 10 + hourSet0, 23);
    press(1, 0, 0);
    press(0, 0, 1);
    chk("clamp_20", hourSet1 * 10 + hourSet0, 20);
    repeat (3) press(1, 0, 0);

    // Simultaneous buttons: Set+Alm in IDLE, Up+Set in EDIT_H0
    press(1, 1, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    repeat (4) press(0, 0, 1);
    chk("simul_h0_pre", hourSet0, 4);
    press(1, 0, 1);
    chk("simul_h0", hourSet0, 5);
    chk("simul_digitSel", digitSel, 2);
    repeat (2) press(1, 0, 0);

    // Debounce: glitch rejected, held button increments once after 2+DB cycles (+1 to register)
    press(1, 0, 0);
    @(posedge clk); #1 btnUp = 1;
    repeat (DB - 1) @(posedge clk);
    #1 btnUp = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("glitch_h1", hourSet1, md[0]);
    check_state();
    @(posedge clk); #1 btnUp = 1;
    repeat (2 + DB) @(posedge clk);
    @(negedge clk);
    chk("up_latency_before", hourSet1, md[0]);
    @(posedge clk);
    @(negedge clk);
    model_apply(0, 0, 1);
    chk("up_latency_after", hourSet1, md[0]);
    repeat (40 - (3 + DB)) @(posedge clk);
    #1 btnUp = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_state();
    repeat (4) press(1, 0, 0);

    // Random button traffic
    repeat (120) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      mask = 4;
      else if (r <= 7) mask = 1;
      else if (r == 8) mask = 2;
      else             mask = $urandom_range(1, 7);
      press(mask[0], mask[1], mask[2]);
    end
    for (int k = 0; k < 5 && m_edit; k++) press(1, 0, 0);
    chk("final_idle", editing, 0);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
